// File: rtl/mmio_timer_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mmio_timer_responder - prescaled 32-bit timer on the data-memory bus     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mmio_timer_responder #(
    parameter logic [31:0] BASE    = 32'h0000_FF00,
    parameter int          PRESC_W = 8
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [31:0] Address,
    input  logic        Wr,
    input  logic [31:0] Datain,
    output logic [31:0] Dataout,
    output logic        Sel,
    output logic        Irq
);

    localparam logic [31:0] CTRL_MASK = 32'h0000_0007 | (((32'h1 << PRESC_W) - 32'h1) << 8);

    logic [31:0]        ctrl;
    logic [31:0]        count;
    logic [31:0]        compare;
    logic               match;
    logic               ovf;
    logic [PRESC_W-1:0] presc_cnt;

    logic               en;
    logic               auto_clr;
    logic [PRESC_W-1:0] presc;
    logic               wr_hit;
    logic               wr_ctrl;
    logic               wr_count;
    logic               wr_compare;
    logic               wr_status;
    logic               tick;
    logic [31:0]        count_inc;
    logic               match_set;
    logic               ovf_set;
    logic               match_next;
    logic               ovf_next;
    logic [31:0]        ctrl_next;
    logic [31:0]        rdata;

    // Byte-lane bits are don't-care for word-wide registers.
    logic unused_addr_bits;
    assign unused_addr_bits = &{1'b0, Address[1:0]};

    assign Sel      = (Address[31:4] == BASE[31:4]);
    assign en       = ctrl[0];
    assign auto_clr = ctrl[1];
    assign presc    = ctrl[8 +: PRESC_W];

    assign wr_hit     = Sel & Wr;
    assign wr_ctrl    = wr_hit & (Address[3:2] == 2'd0);
    assign wr_count   = wr_hit & (Address[3:2] == 2'd1);
    assign wr_compare = wr_hit & (Address[3:2] == 2'd2);
    assign wr_status  = wr_hit & (Address[3:2] == 2'd3);

    always_comb begin
        tick       = en && (presc_cnt == presc);
        count_inc  = count + 32'd1;
        // A software COUNT load suppresses both the increment and its flag side effects.
        ovf_set    = tick && !wr_count && (count == 32'hFFFF_FFFF);
        match_set  = tick && !wr_count && (count_inc == compare);
        match_next = match_set | (match & ~(wr_status & Datain[0]));
        ovf_next   = ovf_set   | (ovf   & ~(wr_status & Datain[1]));
        ctrl_next  = wr_ctrl ? (Datain & CTRL_MASK) : ctrl;
        case (Address[3:2])
            2'd0:    rdata = ctrl;
            2'd1:    rdata = count;
            2'd2:    rdata = compare;
            default: rdata = {30'd0, ovf, match};
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            ctrl      <= 32'd0;
            count     <= 32'd0;
            compare   <= 32'd0;
            match     <= 1'b0;
            ovf       <= 1'b0;
            presc_cnt <= '0;
            Dataout   <= 32'd0;
            Irq       <= 1'b0;
        end else begin
            ctrl <= ctrl_next;
            if (wr_compare) begin
                compare <= Datain;
            end
            if (wr_count) begin
                count     <= Datain;
                presc_cnt <= '0;
            end else begin
                if (!en || tick) begin
                    presc_cnt <= '0;
                end else begin
                    presc_cnt <= presc_cnt + PRESC_W'(1);
                end
                if (tick) begin
                    count <= (match_set && auto_clr) ? 32'd0 : count_inc;
                end
            end
            match   <= match_next;
            ovf     <= ovf_next;
            // Irq is derived from next-state flags so it tracks them without lag.
            Irq     <= ctrl_next[2] & (match_next | ovf_next);
            Dataout <= Sel ? rdata : 32'd0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mmio_timer_responder.sv
`default_nettype none
// Directed self-checking bench for mmio_timer_responder.
module tb_mmio_timer_responder;

    logic        clk;
    logic        rst;
    logic [31:0] address;
    logic        wr;
    logic [31:0] datain;
    logic [31:0] dataout;
    logic        sel;
    logic        irq;

    int checks = 0;
    int errors = 0;

    mmio_timer_responder #(
        .BASE    (32'h0000_FF00),
        .PRESC_W (8)
    ) dut (
        .Clock   (clk),
        .Reset   (rst),
        .Address (address),
        .Wr      (wr),
        .Datain  (datain),
        .Dataout (dataout),
        .Sel     (sel),
        .Irq     (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; address = 32'd0; wr = 1'b0; datain = 32'd0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        address = addr; wr = 1'b1; datain = data;
        @(posedge clk);
        #1;
        wr = 1'b0; address = 32'd0; datain = 32'd0;
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
        @(negedge clk);
        address = addr; wr = 1'b0;
        @(posedge clk);
        #1;
        data = dataout;
    endtask

    logic [31:0] rd;
    logic [31:0] exp_cnt [7] = '{0, 1, 2, 3, 4, 0, 1};
    logic [31:0] bad_addr [2] = '{32'h0000_FE00, 32'h0000_FF10};

    initial begin
        clk = 1'b0; rst = 1'b1; address = 32'd0; wr = 1'b0; datain = 32'd0;
        #1;
        check("rst_dataout", dataout, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        do_reset();

        // Reset values visible through the bus.
        bus_read(32'h0000_FF00, rd); check("rst_ctrl", rd, 32'd0);
        bus_read(32'h0000_FF04, rd); check("rst_count", rd, 32'd0);
        bus_read(32'h0000_FF0C, rd); check("rst_status", rd, 32'd0);

        // PRESC=0: one increment per cycle, 1-cycle read latency.
        do_reset();
        bus_write(32'h0000_FF00, 32'h0000_0001);
        address = 32'h0000_FF04;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("cnt_presc0", dataout, 32'(i));
        end

        // Asynchronous reset mid-count with PRESC=3.
        do_reset();
        bus_write(32'h0000_FF00, 32'h0000_0301);
        address = 32'h0000_FF04;
        repeat (12) @(posedge clk);
        #1;
        check("pre_rst_dout", dataout, 32'd2);
        #2 rst = 1'b1;
        #1;
        check("async_rst_dout", dataout, 32'd0);
        check("async_rst_irq", {31'd0, irq}, 32'd0);
        @(negedge clk); rst = 1'b0;
        repeat (8) @(posedge clk);
        bus_read(32'h0000_FF04, rd); check("post_rst_count", rd, 32'd0);
        bus_read(32'h0000_FF00, rd); check("post_rst_ctrl", rd, 32'd0);
        bus_read(32'h0000_FF0C, rd); check("post_rst_status", rd, 32'd0);

        // PRESC=3: tick every 4 cycles; COUNT load restarts the prescaler.
        do_reset();
        bus_write(32'h0000_FF00, 32'h0000_0301);
        address = 32'h0000_FF04;
        for (int k = 2; k <= 13; k++) begin
            @(posedge clk); #1;
            check("cnt_presc3", dataout, 32'((k > 5) + (k > 9)));
        end
        bus_write(32'h0000_FF04, 32'd100);
        address = 32'h0000_FF04;
        for (int k = 15; k <= 19; k++) begin
            @(posedge clk); #1;
            check("cnt_after_load", dataout, (k > 18) ? 32'd101 : 32'd100);
        end

        // COMPARE match with AUTO_CLR and IRQ_EN, then W1C.
        do_reset();
        bus_write(32'h0000_FF08, 32'd5);
        bus_write(32'h0000_FF00, 32'h0000_0007);
        address = 32'h0000_FF04;
        for (int k = 3; k <= 9; k++) begin
            @(posedge clk); #1;
            check("cnt_match", dataout, exp_cnt[k-3]);
            check("irq_match", {31'd0, irq}, (k >= 7) ? 32'd1 : 32'd0);
        end
        bus_read(32'h0000_FF0C, rd); check("status_match", rd, 32'd1);
        bus_write(32'h0000_FF0C, 32'd1);
        check("irq_after_w1c", {31'd0, irq}, 32'd0);
        bus_read(32'h0000_FF0C, rd); check("status_after_w1c", rd, 32'd0);

        // Overflow, then W1C colliding with a fresh MATCH.
        do_reset();
        bus_write(32'h0000_FF08, 32'd3);
        bus_write(32'h0000_FF04, 32'hFFFF_FFFE);
        bus_write(32'h0000_FF00, 32'h0000_0001);
        bus_read(32'h0000_FF04, rd); check("ovf_cnt0", rd, 32'hFFFF_FFFE);
        bus_read(32'h0000_FF04, rd); check("ovf_cnt1", rd, 32'hFFFF_FFFF);
        bus_read(32'h0000_FF04, rd); check("ovf_cnt2", rd, 32'h0000_0000);
        bus_read(32'h0000_FF0C, rd); check("ovf_status", rd, 32'd2);
        bus_write(32'h0000_FF0C, 32'd3);
        bus_read(32'h0000_FF0C, rd); check("set_beats_clr", rd, 32'd1);
        check("irq_gated", {31'd0, irq}, 32'd0);
        bus_read(32'h0000_FF04, rd); check("no_autoclr_cnt", rd, 32'd4);

        // Accesses outside the window.
        do_reset();
        bus_write(32'h0000_FF08, 32'h0000_0055);
        foreach (bad_addr[j]) begin
            @(negedge clk);
            address = bad_addr[j]; wr = 1'b1; datain = 32'h0000_0301;
            #1;
            check("sel_outside", {31'd0, sel}, 32'd0);
            @(posedge clk); #1;
            check("dout_outside", dataout, 32'd0);
        end
        wr = 1'b0;
        bus_read(32'h0000_FE08, rd); check("read_outside", rd, 32'd0);
        bus_read(32'h0000_FF00, rd); check("ctrl_untouched", rd, 32'd0);
        bus_read(32'h0000_FF08, rd); check("cmp_untouched", rd, 32'h0000_0055);
        @(negedge clk);
        address = 32'h0000_FF0C;
        #1;
        check("sel_inside", {31'd0, sel}, 32'd1);

        // Unimplemented CTRL bits read back as zero.
        bus_write(32'h0000_FF00, 32'hFFFF_FFFF);
        bus_read(32'h0000_FF00, rd); check("ctrl_mask", rd, 32'h0000_FF07);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
